// File: rtl/conv_ctrl_fsm_param_if.sv
// Handshake and datapath-control bundle between the convolution sequencer and its environment.
// The sequencer side uses the master modport; the datapath or testbench side uses slave.
interface conv_ctrl_fsm_param_if #(
   parameter int KLOAD_WORDS = 12,
   parameter int ILOAD_WORDS = 4
);
   localparam int IW = (ILOAD_WORDS > 1) ? $clog2(ILOAD_WORDS) : 1;

   logic                   start;
   logic                   running;
   logic                   done;
   logic                   con_valid;
   logic                   con_ready;
   logic                   output_valid;
   logic                   output_ready;
   logic [31:0]            output_x;
   logic [31:0]            output_y;
   logic [31:0]            output_ch;
   logic [KLOAD_WORDS-1:0] ctrl_KDS_LE_select;
   logic                   ctrl_to_KDS_cycle_enable;
   logic [IW-1:0]          ctrl_IDSS_LE_select;
   logic                   ctrl_IDSS_shift;
   logic                   ctrl_ODS_shift;
   logic [31:0]            stall_cycles;

   modport master (
      input  start, con_valid, output_ready,
      output running, done, con_ready, output_valid, output_x, output_y, output_ch,
             ctrl_KDS_LE_select, ctrl_to_KDS_cycle_enable, ctrl_IDSS_LE_select,
             ctrl_IDSS_shift, ctrl_ODS_shift, stall_cycles
   );

   modport slave (
      output start, con_valid, output_ready,
      input  running, done, con_ready, output_valid, output_x, output_y, output_ch,
             ctrl_KDS_LE_select, ctrl_to_KDS_cycle_enable, ctrl_IDSS_LE_select,
             ctrl_IDSS_shift, ctrl_ODS_shift, stall_cycles
   );
endinterface

// File: rtl/conv_ctrl_fsm_param.sv
// Convolution sequencer: kernel load, input priming, column compute and pipelined result emit.
// Define CONV_CTRL_STALL_CNT_EN to add a saturating handshake-stall counter on stall_cycles.
module conv_ctrl_fsm_param #(
   parameter int FEATURE_MAP_WIDTH  = 1024,
   parameter int FEATURE_MAP_HEIGHT = 1024,
   parameter int OUTPUT_NB_CHANNELS = 64,
   parameter int PAR_OUT            = 6,
   parameter int OUT_LANES          = 3,
   parameter int KERNEL_SIZE        = 3,
   parameter int KLOAD_WORDS        = 12,
   parameter int KGROUPS            = 6,
   parameter int ILOAD_WORDS        = 4
) (
   input  logic                 clk,
   input  logic                 arst_n_in,
   conv_ctrl_fsm_param_if.master bus
);
   localparam int NBEATS = PAR_OUT / OUT_LANES;
   localparam int KWW    = (KLOAD_WORDS > 1) ? $clog2(KLOAD_WORDS) : 1;
   localparam int KGW    = (KGROUPS > 1) ? $clog2(KGROUPS) : 1;
   localparam int IW     = (ILOAD_WORDS > 1) ? $clog2(ILOAD_WORDS) : 1;
   localparam int PW     = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD_K  = 3'd1;
   localparam logic [2:0] S_LOAD_I  = 3'd2;
   localparam logic [2:0] S_SHIFT_I = 3'd3;
   localparam logic [2:0] S_COMPUTE = 3'd4;
   localparam logic [2:0] S_EMIT    = 3'd5;

   logic [2:0]     state;
   logic [KWW-1:0] kword;
   logic [KGW-1:0] kgrp;
   logic [IW-1:0]  iword;
   logic [PW-1:0]  prime;
   logic [BW-1:0]  beat;
   logic [31:0]    x, y, ch_base;
   logic [31:0]    tag_x, tag_y, tag_ch;
   logic           pending, drain, done_q;

   logic con_rdy, xfer, emit;
   logic last_kword, last_kgrp, last_iword, last_prime, last_beat;
   logic last_x, last_y, last_pass;

   assign con_rdy    = (state == S_LOAD_K) || (state == S_LOAD_I) || (state == S_COMPUTE);
   assign xfer       = con_rdy && bus.con_valid;
   assign emit       = (state == S_EMIT);
   assign last_kword = (kword == KWW'(KLOAD_WORDS - 1));
   assign last_kgrp  = (kgrp == KGW'(KGROUPS - 1));
   assign last_iword = (iword == IW'(ILOAD_WORDS - 1));
   assign last_prime = (prime == PW'(KERNEL_SIZE - 1));
   assign last_beat  = (beat == BW'(NBEATS - 1));
   assign last_x     = (x == 32'(FEATURE_MAP_WIDTH - 1));
   assign last_y     = (y == 32'(FEATURE_MAP_HEIGHT - 1));
   assign last_pass  = (ch_base + 32'(PAR_OUT) >= 32'(OUTPUT_NB_CHANNELS));

   assign bus.running                  = (state != S_IDLE);
   assign bus.done                     = done_q;
   assign bus.con_ready                = con_rdy;
   assign bus.output_valid             = emit;
   assign bus.output_x                 = emit ? tag_x : '0;
   assign bus.output_y                 = emit ? tag_y : '0;
   assign bus.output_ch                = emit ? (tag_ch + 32'(beat) * 32'(OUT_LANES)) : '0;
   assign bus.ctrl_KDS_LE_select       = (state == S_LOAD_K) ? (KLOAD_WORDS'(1) << kword) : '0;
   assign bus.ctrl_to_KDS_cycle_enable = (state == S_COMPUTE) && xfer;
   assign bus.ctrl_IDSS_LE_select      = ((state == S_LOAD_I) || (state == S_COMPUTE)) ? iword : '0;
   assign bus.ctrl_IDSS_shift          = (state == S_SHIFT_I) || ((state == S_COMPUTE) && xfer && last_iword);
   assign bus.ctrl_ODS_shift           = emit && bus.output_ready;

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state   <= S_IDLE;
         kword   <= '0;
         kgrp    <= '0;
         iword   <= '0;
         prime   <= '0;
         beat    <= '0;
         x       <= '0;
         y       <= '0;
         ch_base <= '0;
         tag_x   <= '0;
         tag_y   <= '0;
         tag_ch  <= '0;
         pending <= 1'b0;
         drain   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: if (bus.start) begin
               x       <= '0;
               y       <= '0;
               ch_base <= '0;
               kword   <= '0;
               kgrp    <= '0;
               iword   <= '0;
               prime   <= '0;
               beat    <= '0;
               pending <= 1'b0;
               drain   <= 1'b0;
               state   <= S_LOAD_K;
            end
            S_LOAD_K: if (xfer) begin
               if (last_kword) begin
                  kword <= '0;
                  if (last_kgrp) begin
                     kgrp  <= '0;
                     state <= S_LOAD_I;
                  end else begin
                     kgrp <= kgrp + 1'b1;
                  end
               end else begin
                  kword <= kword + 1'b1;
               end
            end
            S_LOAD_I: if (xfer) begin
               if (last_iword) begin
                  iword <= '0;
                  state <= S_SHIFT_I;
               end else begin
                  iword <= iword + 1'b1;
               end
            end
            S_SHIFT_I: if (last_prime) begin
               prime   <= '0;
               x       <= '0;
               pending <= 1'b0;
               state   <= S_COMPUTE;
            end else begin
               prime <= prime + 1'b1;
               state <= S_LOAD_I;
            end
            // Results lag one column: a finished column is emitted only once the next one is done.
            S_COMPUTE: if (xfer) begin
               if (last_iword) begin
                  iword <= '0;
                  if (pending) begin
                     state <= S_EMIT;
                  end else begin
                     pending <= 1'b1;
                     tag_x   <= x;
                     tag_y   <= y;
                     tag_ch  <= ch_base;
                     x       <= x + 32'd1;
                  end
               end else begin
                  iword <= iword + 1'b1;
               end
            end
            S_EMIT: if (bus.output_ready) begin
               if (!last_beat) begin
                  beat <= beat + 1'b1;
               end else begin
                  beat <= '0;
                  if (!drain) begin
                     tag_x  <= x;
                     tag_y  <= y;
                     tag_ch <= ch_base;
                     if (last_x) begin
                        drain <= 1'b1;
                     end else begin
                        x     <= x + 32'd1;
                        state <= S_COMPUTE;
                     end
                  end else begin
                     drain   <= 1'b0;
                     pending <= 1'b0;
                     if (!last_y) begin
                        y     <= y + 32'd1;
                        state <= S_LOAD_I;
                     end else if (last_pass) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                     end else begin
                        ch_base <= ch_base + 32'(PAR_OUT);
                        y       <= '0;
                        state   <= S_LOAD_K;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef CONV_CTRL_STALL_CNT_EN
   logic        stall_ev;
   logic [31:0] stall_q;

   assign stall_ev = (con_rdy && !bus.con_valid) || (emit && !bus.output_ready);

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         stall_q <= '0;
      end else if ((state == S_IDLE) && bus.start) begin
         stall_q <= '0;
      end else if (stall_ev && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign bus.stall_cycles = stall_q;
`else
   assign bus.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_conv_ctrl_fsm_param.sv
// Testbench: random handshakes on a small two-row, two-pass configuration, checked against
// a loop-nest model of the expected beat sequence and word counts.
module tb_conv_ctrl_fsm_param;
   localparam int W    = 3;
   localparam int H    = 2;
   localparam int OC   = 8;
   localparam int PO   = 6;
   localparam int OL   = 3;
   localparam int KS   = 3;
   localparam int KLW  = 12;
   localparam int KG   = 2;
   localparam int ILW  = 4;
   localparam int NPASS = (OC + PO - 1) / PO;

   typedef struct { int x; int y; int ch; } beat_t;

   logic clk;
   logic arst_n;
   conv_ctrl_fsm_param_if #(.KLOAD_WORDS(KLW), .ILOAD_WORDS(ILW)) bus ();

   conv_ctrl_fsm_param #(
      .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(OC),
      .PAR_OUT(PO), .OUT_LANES(OL), .KERNEL_SIZE(KS),
      .KLOAD_WORDS(KLW), .KGROUPS(KG), .ILOAD_WORDS(ILW)
   ) dut (
      .clk(clk),
      .arst_n_in(arst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   beat_t exp_q[$];
   int kxf, ixf, shift_cnt, done_cnt, exp_stall;
   bit mon_en = 0;
   bit held_vld;
   logic [31:0] hx, hy, hch;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      exp_q.delete();
      for (int cb = 0; cb < OC; cb += PO)
         for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
               for (int b = 0; b < PO / OL; b++)
                  exp_q.push_back('{xx, yy, cb + b * OL});
      kxf = 0; ixf = 0; shift_cnt = 0; done_cnt = 0; exp_stall = 0; held_vld = 0;
   endtask

   // Sampled mid-cycle, so every observation here describes the transfer at the next rising edge.
   always @(negedge clk) begin
      int col;
      bit comp;
      if (mon_en) begin
         if (bus.con_ready && bus.con_valid) begin
            if (bus.ctrl_KDS_LE_select != '0) begin
               chk("kds_sel", 64'(bus.ctrl_KDS_LE_select), 64'(1) << (kxf % KLW));
               kxf++;
            end else begin
               col  = (ixf / ILW) % (KS + W);
               comp = (col >= KS);
               chk("idss_sel", 64'(bus.ctrl_IDSS_LE_select), 64'(ixf % ILW));
               chk("cyc_en", 64'(bus.ctrl_to_KDS_cycle_enable), 64'(comp));
               chk("idss_shift_xfer", 64'(bus.ctrl_IDSS_shift), 64'(comp && (ixf % ILW == ILW - 1)));
               ixf++;
            end
         end
         if (bus.ctrl_IDSS_shift) shift_cnt++;
         if (held_vld) begin
            chk("hold_vld", 64'(bus.output_valid), 64'(1));
            chk("hold_x", 64'(bus.output_x), 64'(hx));
            chk("hold_y", 64'(bus.output_y), 64'(hy));
            chk("hold_ch", 64'(bus.output_ch), 64'(hch));
            held_vld = 0;
         end
         if (bus.output_valid) begin
            if (bus.output_ready) begin
               chk("ods_shift", 64'(bus.ctrl_ODS_shift), 64'(1));
               chk("beat_avail", 64'(exp_q.size() > 0), 64'(1));
               if (exp_q.size() > 0) begin
                  chk("beat_x", 64'(bus.output_x), 64'(exp_q[0].x));
                  chk("beat_y", 64'(bus.output_y), 64'(exp_q[0].y));
                  chk("beat_ch", 64'(bus.output_ch), 64'(exp_q[0].ch));
                  void'(exp_q.pop_front());
               end
            end else begin
               chk("ods_stalled", 64'(bus.ctrl_ODS_shift), 64'(0));
               held_vld = 1;
               hx = bus.output_x; hy = bus.output_y; hch = bus.output_ch;
            end
         end
         chk("excl", 64'(bus.con_ready && bus.output_valid), 64'(0));
         if ((bus.con_ready && !bus.con_valid) || (bus.output_valid && !bus.output_ready))
            exp_stall++;
         if (bus.done) begin
            done_cnt++;
            chk("done_idle", 64'(bus.running), 64'(0));
            chk("done_q_empty", 64'(exp_q.size()), 64'(0));
         end
      end
   end

   task automatic run_rand(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(posedge clk); #1;
         bus.con_valid    = ($urandom_range(0, 3) != 0);
         bus.output_ready = ($urandom_range(0, 3) != 0);
         bus.start        = bus.running && ($urandom_range(0, 40) == 0);
         n++;
      end
      bus.start = 1'b0;
      chk("job_done", 64'(done_cnt), 64'(1));
   endtask

   task automatic end_job_checks();
      @(posedge clk); #1;
      chk("done_pulse", 64'(bus.done), 64'(0));
      chk("done_cnt", 64'(done_cnt), 64'(1));
      chk("running_end", 64'(bus.running), 64'(0));
      chk("k_words", 64'(kxf), 64'(NPASS * KLW * KG));
      chk("i_words", 64'(ixf), 64'(NPASS * H * (KS + W) * ILW));
      chk("idss_shifts", 64'(shift_cnt), 64'(NPASS * H * (KS + W)));
      chk("beats_left", 64'(exp_q.size()), 64'(0));
`ifdef CONV_CTRL_STALL_CNT_EN
      chk("stall_total", 64'(bus.stall_cycles), 64'(exp_stall));
`else
      chk("stall_total", 64'(bus.stall_cycles), 64'(0));
`endif
   endtask

   initial begin
      int n;
      logic [31:0] s0, ex, ey, ech;
      arst_n = 1'b0;
      bus.start = 1'b0; bus.con_valid = 1'b0; bus.output_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_running", 64'(bus.running), 64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));
      chk("rst_con_ready", 64'(bus.con_ready), 64'(0));
      chk("rst_out_valid", 64'(bus.output_valid), 64'(0));
      chk("rst_kds", 64'(bus.ctrl_KDS_LE_select), 64'(0));
      chk("rst_idss_sel", 64'(bus.ctrl_IDSS_LE_select), 64'(0));
      chk("rst_stall", 64'(bus.stall_cycles), 64'(0));
      arst_n = 1'b1;

      // Job 1: kernel-load hold at word 7, then a five-cycle output stall, then random traffic.
      @(posedge clk); #1;
      reset_model(); mon_en = 1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("running_start", 64'(bus.running), 64'(1));
      bus.con_valid = 1'b1; bus.output_ready = 1'b1;
      repeat (7) begin @(posedge clk); #1; end
      bus.con_valid = 1'b0;
      chk("kds_hold0", 64'(bus.ctrl_KDS_LE_select), 64'(1) << 7);
      repeat (3) begin @(posedge clk); #1; end
      chk("kds_hold3", 64'(bus.ctrl_KDS_LE_select), 64'(1) << 7);
      bus.con_valid = 1'b1;
      n = 0;
      while (!bus.output_valid && n < 2000) begin @(posedge clk); #1; n++; end
      chk("emit_reached", 64'(bus.output_valid), 64'(1));
      chk("first_x", 64'(bus.output_x), 64'(0));
      chk("first_y", 64'(bus.output_y), 64'(0));
      chk("first_ch", 64'(bus.output_ch), 64'(0));
      bus.output_ready = 1'b0;
      s0 = bus.stall_cycles; ex = bus.output_x; ey = bus.output_y; ech = bus.output_ch;
      repeat (5) begin @(posedge clk); #1; end
      chk("stall_vld", 64'(bus.output_valid), 64'(1));
      chk("stall_x", 64'(bus.output_x), 64'(ex));
      chk("stall_y", 64'(bus.output_y), 64'(ey));
      chk("stall_ch", 64'(bus.output_ch), 64'(ech));
`ifdef CONV_CTRL_STALL_CNT_EN
      chk("stall_delta", 64'(bus.stall_cycles - s0), 64'(5));
`else
      chk("stall_delta", 64'(bus.stall_cycles - s0), 64'(0));
`endif
      run_rand(6000);
      end_job_checks();

      // Job 2: asynchronous reset while columns are being computed.
      reset_model();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.con_valid = 1'b1; bus.output_ready = 1'b1;
      n = 0;
      while (!bus.ctrl_to_KDS_cycle_enable && n < 2000) begin @(posedge clk); #1; n++; end
      chk("compute_reached", 64'(bus.ctrl_to_KDS_cycle_enable), 64'(1));
      mon_en = 0;
      #2 arst_n = 1'b0;
      #1;
      chk("arst_running", 64'(bus.running), 64'(0));
      chk("arst_con_ready", 64'(bus.con_ready), 64'(0));
      chk("arst_idss_sel", 64'(bus.ctrl_IDSS_LE_select), 64'(0));
      chk("arst_cyc_en", 64'(bus.ctrl_to_KDS_cycle_enable), 64'(0));
      chk("arst_stall", 64'(bus.stall_cycles), 64'(0));
      @(posedge clk); #1;
      arst_n = 1'b1;

      // Job 3: full rerun after reset must restart from the origin.
      @(posedge clk); #1;
      reset_model(); mon_en = 1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      run_rand(6000);
      end_job_checks();
      mon_en = 0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
